mux_reg_arbiter: RTL
====================

// Module: mux_reg_arbiter
// PURPOSE
//  Shares one 2:1 mux-input register (d0/d1/sel/rst -> q, sync active-high reset)
//  between two write requesters and one clear requester. Grants round-robin
//  between the writers and drives the register's sel/d0/d1/rst.
//  Reads back q one cycle after capture and checks it against the intended value.
//  Sits between requester logic and the shared register; the register itself stays unchanged.
// PARAMETERS
//  WIDTH     1   data width of d0/d1/q and of requester data
// PORTS
//  clk       in   1      system clock, all state on posedge
//  rst       in   1      synchronous, active-high reset
//  req0      in   1      write request, requester 0 (held until gnt0)
//  data0     in   WIDTH  write data, requester 0 (stable while req0)
//  req1      in   1      write request, requester 1 (held until gnt1)
//  data1     in   WIDTH  write data, requester 1 (stable while req1)
//  clr_req   in   1      clear request (held until clr_ack)
//  q         in   WIDTH  shared register output
//  sel       out  1      mux select to register: 0=d0, 1=d1
//  d0        out  WIDTH  register input 0 (requester 0 path)
//  d1        out  WIDTH  register input 1 (requester 1 path)
//  reg_rst   out  1      register reset = rst | (state==CLEAR)
//  gnt0/gnt1 out  1      1-cycle pulse: write done for that requester
//  clr_ack   out  1      1-cycle pulse: clear done
//  err       out  1      1-cycle pulse with gnt/clr_ack when q readback mismatches
//  busy      out  1      high in any state other than IDLE
// BEHAVIOUR
//  - All outputs are registered except reg_rst.
//  - Reset (rst=1 at posedge): state=IDLE, ptr=0 (req0 favoured), sel=0, d0=d1=0.
//    gnt0/gnt1/clr_ack/err=0, busy=0. reg_rst=1 while rst=1.
//  - Reset mid-operation aborts the transaction: no gnt/ack is issued.
//    The requester keeps its req asserted and is served again after reset.
//  - FSM states: IDLE, LOAD, CLEAR, VERIFY.
//  - IDLE: priority clr_req > writers.
//    - clr_req=1 -> CLEAR; expected value exp=0.
//    - Else if only one writer requests -> that writer.
//    - Else if both request -> writer ptr.
//    - Writer k selected -> sel=k, dk=datak, other d held at its old value,
//      exp=datak, owner=k, next state LOAD.
//  - LOAD (1 cycle): register captures the mux output at the posedge ending LOAD -> VERIFY.
//  - CLEAR (1 cycle): reg_rst=1; register clears at the posedge ending CLEAR -> VERIFY.
//  - VERIFY (1 cycle): compare q vs exp.
//    - Pulse gnt[owner] or clr_ack; err=(q!==exp).
//    - On a write, ptr=~owner; a clear does not change ptr.
//    - Next state IDLE. Requesters drop req in the cycle after the gnt.
//  - Timing: request first seen in IDLE at edge N -> gnt/ack high in cycle N+2 -> back in IDLE at N+3.
//    Service interval is 3 cycles per transaction.
//  - A req still high in the cycle right after its gnt is treated as a new request.
//  - sel/d0/d1 keep their last values outside LOAD; the register holds q through its own path.
//  - Both writers continuously requesting -> strict alternation 0,1,0,1...
//  - clr_req held continuously starves the writers (by design; system guarantees clr is rare).
// TESTING
//  1. rst=1 for 2 clk -> reg_rst=1, sel=0, d0=d1=0, all pulses 0, busy=0; q==0 after release.
//  2. req0=1,data0=1 (WIDTH=1) -> sel=0,d0=1 in LOAD; gnt0 pulse 2 cycles later, q=1, err=0.
//  3. req0 & req1 together, data0=0, data1=1 -> gnt0 first (q=0), then gnt1 (q=1); ptr back to 0.
//  4. clr_req with req1 pending, q=1 -> CLEAR first: reg_rst pulse, clr_ack, q=0; then gnt1.
//  5. Force q stuck at 0 (disconnect the register), req1 with data1=1 -> gnt1 with err=1.
//  6. Assert rst while in LOAD -> no gnt0, state IDLE; req0 still high -> served with gnt0 after reset.

Source files
------------

// File: rtl/mux_reg_arbiter.sv
// mux_reg_arbiter: round-robin write/clear arbiter driving a shared 2:1 mux register, with q readback check
module mux_reg_arbiter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic             req1_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic             clr_req_i,
  input  logic [WIDTH-1:0] q_i,
  output logic             sel_o,
  output logic [WIDTH-1:0] d0_o,
  output logic [WIDTH-1:0] d1_o,
  output logic             reg_rst_o,
  output logic             gnt0_o,
  output logic             gnt1_o,
  output logic             clr_ack_o,
  output logic             err_o,
  output logic             busy_o
);
  typedef enum logic [1:0] {IDLE, LOAD, CLEAR, VERIFY} state_t;
  state_t state_q, state_d;
  logic ptr_q, owner_q, owner_d, is_clr_q, go_wr, start_clr, start_wr, vfy;
  logic sel_q, gnt0_q, gnt1_q, clr_ack_q, err_q;
  logic [WIDTH-1:0] exp_q, d0_q, d1_q;
  always_comb begin
    go_wr = req0_i | req1_i;
    owner_d = (req0_i & req1_i) ? ptr_q : req1_i;
    start_clr = (state_q == IDLE) & clr_req_i;
    start_wr = (state_q == IDLE) & ~clr_req_i & go_wr;
    vfy = state_q == VERIFY;
    state_d = state_q == IDLE ? (clr_req_i ? CLEAR : go_wr ? LOAD : IDLE)
            : vfy ? IDLE : VERIFY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      owner_q <= 1'b0;
      is_clr_q <= 1'b0;
      exp_q <= '0;
      sel_q <= 1'b0;
      d0_q <= '0;
      d1_q <= '0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      clr_ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt0_q <= vfy & ~is_clr_q & ~owner_q;
      gnt1_q <= vfy & ~is_clr_q & owner_q;
      clr_ack_q <= vfy & is_clr_q;
      err_q <= vfy & (q_i != exp_q);
      if (vfy & ~is_clr_q) ptr_q <= ~owner_q;
      if (start_clr) begin
        is_clr_q <= 1'b1;
        exp_q <= '0;
      end else if (start_wr) begin
        is_clr_q <= 1'b0;
        owner_q <= owner_d;
        sel_q <= owner_d;
        exp_q <= owner_d ? data1_i : data0_i;
        if (owner_d) d1_q <= data1_i;
        else d0_q <= data0_i;
      end
    end
  end
  assign sel_o = sel_q;
  assign d0_o = d0_q;
  assign d1_o = d1_q;
  assign reg_rst_o = rst | (state_q == CLEAR);
  assign gnt0_o = gnt0_q;
  assign gnt1_o = gnt1_q;
  assign clr_ack_o = clr_ack_q;
  assign err_o = err_q;
  assign busy_o = state_q != IDLE;
endmodule
